// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes for the iterative mul/div unit, its FSM states,
// and the result-mux select code assigned to that unit.
package alu_pkg;

  localparam logic [1:0] MD_MUL  = 2'b00;
  localparam logic [1:0] MD_MULH = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;
  localparam logic [1:0] MD_REM  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam logic [2:0] RES_SEL_MULDIV = 3'd6;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned mul/div, one radix-2 step per cycle: result and done WIDTH cycles after start.
// No backpressure: start is accepted only when not busy; starts while busy are dropped.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] hi_n, lo_n, res_n;
  logic [WIDTH:0]   lhs, sum;
  logic [WIDTH-1:0] hi_add;
  logic             carry;
  logic             accept, last, is_div;

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign is_div = op_q[1];

  // One shared adder: hi + a for multiply, shifted remainder - b for divide.
  assign lhs = is_div ? {hi, lo[WIDTH-1]} : {1'b0, hi};
  assign sum = is_div ? (lhs - {1'b0, opnd_q}) : (lhs + {1'b0, opnd_q});

  always_comb begin
    hi_n   = hi;
    lo_n   = lo;
    carry  = 1'b0;
    hi_add = hi;
    if (is_div) begin
      hi_n = sum[WIDTH] ? lhs[WIDTH-1:0] : sum[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], ~sum[WIDTH]};
    end else begin
      if (lo[0]) begin
        {carry, hi_add} = sum;
      end
      hi_n = {carry, hi_add[WIDTH-1:1]};
      lo_n = {hi_add[0], lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    res_n = lo_n;
    case (op_q)
      MD_MUL:  res_n = lo_n;
      MD_MULH: res_n = hi_n;
      MD_DIV:  res_n = lo_n;
      MD_REM:  res_n = hi_n;
      default: res_n = lo_n;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_q   <= MD_MUL;
      opnd_q <= '0;
      hi     <= '0;
      lo     <= '0;
      result <= '0;
    end else if (accept) begin
      // Multiply keeps a as the addend and b in lo; divide keeps b as divisor and a in lo.
      cnt    <= '0;
      op_q   <= op;
      opnd_q <= op[1] ? b : a;
      hi     <= '0;
      lo     <= op[1] ? a : b;
    end else if (state == RUN) begin
      hi <= hi_n;
      lo <= lo_n;
      if (last) begin
        result <= res_n;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Directed and random checks of alu_muldiv_iter against a plain-arithmetic reference model.
module tb_alu_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  alu_muldiv_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = {32'b0, x} * {32'b0, y};
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves at the negedge after the accepting edge with inputs scrambled.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
  endtask

  // Waits for done; n0 = edges already elapsed since the accepting edge.
  task automatic wait_done(input logic [31:0] exp, input string tag, input int n0);
    int n;
    logic bad_busy;
    n = n0;
    bad_busy = 1'b0;
    while (!done && n < 100) begin
      if (busy !== 1'b1) bad_busy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk({tag, "_busy_held"}, 32'(bad_busy), 32'd0);
    chk({tag, "_latency"}, 32'(n), 32'd32);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx, ry;

    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'b00, 32'd7, 32'd6, "mul7x6");
    wait_done(32'd42, "mul7x6", 0);
    @(posedge clk); @(negedge clk);
    chk("mul7x6_done_low", 32'(done), 32'd0);

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ff");
    wait_done(32'h0000_0001, "mul_ff", 0);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_ff");
    wait_done(32'hFFFF_FFFE, "mulh_ff", 0);
    issue(2'b10, 32'd100, 32'd7, "div100_7");
    wait_done(32'd14, "div100_7", 0);
    issue(2'b11, 32'd100, 32'd7, "rem100_7");
    wait_done(32'd2, "rem100_7", 0);
    issue(2'b10, 32'd5, 32'd9, "div5_9");
    wait_done(32'd0, "div5_9", 0);
    issue(2'b11, 32'd5, 32'd9, "rem5_9");
    wait_done(32'd5, "rem5_9", 0);
    issue(2'b10, 32'd5, 32'd0, "div5_0");
    wait_done(32'hFFFF_FFFF, "div5_0", 0);
    issue(2'b11, 32'd5, 32'd0, "rem5_0");
    wait_done(32'd5, "rem5_0", 0);

    // Result holds through idle cycles.
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("hold_result", result, 32'd5);
    chk("hold_idle_busy", 32'(busy), 32'd0);

    // Start while busy is ignored.
    issue(2'b00, 32'd3, 32'd4, "ign");
    repeat (9) begin @(posedge clk); @(negedge clk); end
    op = 2'b10; a = 32'd9; b = 32'd3; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; a = 32'd77; b = 32'd88;
    wait_done(32'd12, "ign", 10);
    @(posedge clk); @(negedge clk);
    chk("ign_single_done", 32'(done), 32'd0);
    chk("ign_no_restart", 32'(busy), 32'd0);

    // Reset mid-operation.
    issue(2'b10, 32'd100, 32'd7, "rstmid");
    repeat (14) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'b00, 32'd2, 32'd3, "mul2x3");
    wait_done(32'd6, "mul2x3", 0);
    // Start in the done cycle.
    issue(2'b00, 32'd5, 32'd5, "b2b");
    wait_done(32'd25, "b2b", 0);

    // Random back-to-back operations, each issued in the previous done cycle.
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(3));
      rx = $urandom;
      case ($urandom_range(3))
        0:       ry = 32'd0;
        1:       ry = $urandom_range(1, 255);
        default: ry = $urandom;
      endcase
      issue(ro, rx, ry, "rand");
      wait_done(model(ro, rx, ry), "rand", 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
